// File: rtl/vga_timing_pkg.sv
// Shared 800x600@72 timing constants, colour codes and the delay-line payload type.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BACK_DEF    = 64;
  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BACK_DEF    = 23;

  function automatic int span_total(int vis, int front, int sync, int back);
    return vis + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = span_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = span_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK  = 3'b000;
  localparam rgb_t RED    = 3'b100;
  localparam rgb_t YELLOW = 3'b110;
  localparam rgb_t WHITE  = 3'b111;
  localparam rgb_t BLUE   = 3'b001;

  // Raster attributes travelling alongside the game engine's pixel latency.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       active;
    logic [2:0] bar;
  } tmg_t;

endpackage

// File: rtl/vga_timing_controller_if.sv
// Pixel-side bundle between the timing controller, game_engine and the VGA pins.
interface vga_timing_controller_if;
  import vga_timing_pkg::*;

  rgb_t             PIXEL;
  logic             TEST_PATTERN;
  logic [CNT_W-1:0] PIXEL_H;
  logic [CNT_W-1:0] PIXEL_V;
  logic             ACTIVE;
  logic             FRAME_START;
  logic             VGA_HS;
  logic             VGA_VS;
  logic             VGA_R;
  logic             VGA_G;
  logic             VGA_B;

  modport master (
    input  PIXEL, TEST_PATTERN,
    output PIXEL_H, PIXEL_V, ACTIVE, FRAME_START,
    output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output PIXEL, TEST_PATTERN,
    input  PIXEL_H, PIXEL_V, ACTIVE, FRAME_START,
    input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register, DEPTH clocks of latency, reset loads RST_VAL into every stage.
module vga_delay_line #(
  parameter int                 WIDTH   = 6,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster generator: free-running counters, syncs/colour out PIXEL_LATENCY+1 clocks after coordinate.
// No back-pressure; PIXEL sampled every clock. VGA_TEST_PATTERN_EN adds a colour-bar source.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = H_VISIBLE_DEF,
  parameter int H_FRONT       = H_FRONT_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BACK        = H_BACK_DEF,
  parameter int V_VISIBLE     = V_VISIBLE_DEF,
  parameter int V_FRONT       = V_FRONT_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BACK        = V_BACK_DEF,
  parameter bit SYNC_ACTIVE   = 1'b1,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic                    VGA_CLOCK,
  input  logic                    RESET,
  vga_timing_controller_if.master vga_if
);

  localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || PIXEL_LATENCY < 1) begin : g_param_check
    $error("vga_timing_controller: totals must fit 11 bits and PIXEL_LATENCY must be >= 1");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             fs_q, fs_d;
  rgb_t             rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             active_raw;
  tmg_t             tmg_raw, tmg_dly;

  always_comb begin
    h_d  = h_q + CNT_W'(1);
    v_d  = v_q;
    fs_d = 1'b0;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d  = '0;
        fs_d = 1'b1;
      end else begin
        v_d = v_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      h_q  <= '0;
      v_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fs_q <= fs_d;
    end
  end

  assign active_raw     = (h_q < H_VIS) && (v_q < V_VIS);
  assign tmg_raw.hs     = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign tmg_raw.vs     = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
  assign tmg_raw.active = active_raw;
  assign tmg_raw.bar    = h_q[9:7];

  // Cleared stages decode as blank with syncs inactive regardless of polarity.
  vga_delay_line #(
    .WIDTH   ($bits(tmg_t)),
    .DEPTH   (PIXEL_LATENCY),
    .RST_VAL ({$bits(tmg_t){1'b0}})
  ) u_delay (
    .clk_i  (VGA_CLOCK),
    .rst_i  (RESET),
    .din_i  (tmg_raw),
    .dout_o (tmg_dly)
  );

  always_comb begin
    rgb_d = tmg_dly.active ? vga_if.PIXEL : BLACK;
`ifdef VGA_TEST_PATTERN_EN
    if (vga_if.TEST_PATTERN) rgb_d = tmg_dly.active ? tmg_dly.bar : BLACK;
`endif
    hs_d = tmg_dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_d = tmg_dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

`ifndef VGA_TEST_PATTERN_EN
  logic unused_test_pattern;
  assign unused_test_pattern = ^{vga_if.TEST_PATTERN, tmg_dly.bar};
`endif

  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      rgb_q <= BLACK;
      hs_q  <= ~SYNC_ACTIVE;
      vs_q  <= ~SYNC_ACTIVE;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vga_if.PIXEL_H     = h_q;
  assign vga_if.PIXEL_V     = v_q;
  assign vga_if.ACTIVE      = active_raw;
  assign vga_if.FRAME_START = fs_q;
  assign vga_if.VGA_HS      = hs_q;
  assign vga_if.VGA_VS      = vs_q;
  assign vga_if.VGA_R       = rgb_q[2];
  assign vga_if.VGA_G       = rgb_q[1];
  assign vga_if.VGA_B       = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench: default 800x600 instance plus a shrunken negative-sync, latency-2 instance,
// both checked every clock against a coordinate-history reference model.
module tb_vga_timing_controller;
  import vga_timing_pkg::*;

  localparam int NCYC = 4000;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, lat;
    bit sa;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_controller_if vif0 ();
  vga_timing_controller_if vif1 ();

  vga_timing_controller u_dut0 (
    .VGA_CLOCK (clk),
    .RESET     (rst),
    .vga_if    (vif0)
  );

  vga_timing_controller #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(3),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b0), .PIXEL_LATENCY(2)
  ) u_dut1 (
    .VGA_CLOCK (clk),
    .RESET     (rst),
    .vga_if    (vif1)
  );

  cfg_t cfg [2];
  int   ch  [2][NCYC];
  int   cv  [2][NCYC];
  bit   hr  [NCYC];
  logic [2:0] hp [NCYC];
  bit   htp [NCYC];
  int   m;
  int   n_assert, n_fail;
  int   rel, hs_cnt, first_hs, vs_cnt;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d edge %0d: observed %0h expected %0h", tag, d, m, obs, exp);
    end
  endtask

  task automatic get_obs(input int d, output logic [31:0] oh, output logic [31:0] ov,
                         output logic [31:0] oa, output logic [31:0] ofs, output logic [31:0] ohs,
                         output logic [31:0] ovs, output logic [31:0] orgb);
    if (d == 0) begin
      oh = 32'(vif0.PIXEL_H); ov = 32'(vif0.PIXEL_V); oa = 32'(vif0.ACTIVE);
      ofs = 32'(vif0.FRAME_START); ohs = 32'(vif0.VGA_HS); ovs = 32'(vif0.VGA_VS);
      orgb = 32'({vif0.VGA_R, vif0.VGA_G, vif0.VGA_B});
    end else begin
      oh = 32'(vif1.PIXEL_H); ov = 32'(vif1.PIXEL_V); oa = 32'(vif1.ACTIVE);
      ofs = 32'(vif1.FRAME_START); ohs = 32'(vif1.VGA_HS); ovs = 32'(vif1.VGA_VS);
      orgb = 32'({vif1.VGA_R, vif1.VGA_G, vif1.VGA_B});
    end
  endtask

  // Expected outputs after edge m: counters show coordinate m, the VGA pins show the
  // coordinate from edge m-1-lat combined with the pixel present at edge m, unless a
  // reset edge falls inside that window.
  task automatic check_dut(input int d);
    logic [31:0] oh, ov, oa, ofs, ohs, ovs, orgb;
    cfg_t c;
    int   eh, ev, j, h, v;
    bit   blank, e_act, d_act, in_hs, in_vs;
    logic [2:0] e_rgb;
    c  = cfg[d];
    eh = ch[d][m];
    ev = cv[d][m];
    e_act = (eh < c.hv) && (ev < c.vv);
    get_obs(d, oh, ov, oa, ofs, ohs, ovs, orgb);
    chk("pixel_h", d, oh, 32'(eh));
    chk("pixel_v", d, ov, 32'(ev));
    chk("active", d, oa, 32'(e_act));
    chk("frame_start", d, ofs, 32'(!hr[m] && eh == 0 && ev == 0));

    j = m - 1 - c.lat;
    blank = hr[m] || (j < 0);
    for (int k = m - c.lat; k < m; k++) if (k < 0 || hr[k]) blank = 1'b1;
    e_rgb = 3'b000;
    in_hs = 1'b0;
    in_vs = 1'b0;
    if (!blank) begin
      h = ch[d][j];
      v = cv[d][j];
      d_act = (h < c.hv) && (v < c.vv);
      in_hs = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs);
      in_vs = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs);
      e_rgb = d_act ? hp[m] : 3'b000;
`ifdef VGA_TEST_PATTERN_EN
      if (htp[m]) e_rgb = d_act ? 3'((h >> 7) & 7) : 3'b000;
`endif
    end
    chk("vga_rgb", d, orgb, 32'(e_rgb));
    chk("vga_hs", d, ohs, 32'(in_hs ? c.sa : !c.sa));
    chk("vga_vs", d, ovs, 32'(in_vs ? c.sa : !c.sa));
  endtask

  task automatic step(input bit r, input logic [2:0] p, input bit tp);
    int ht, vt;
    rst = r;
    vif0.PIXEL = p;
    vif1.PIXEL = p;
    vif0.TEST_PATTERN = tp;
    vif1.TEST_PATTERN = tp;
    @(posedge clk);
    hr[m]  = r;
    hp[m]  = p;
    htp[m] = tp;
    for (int d = 0; d < 2; d++) begin
      ht = cfg[d].hv + cfg[d].hf + cfg[d].hs + cfg[d].hb;
      vt = cfg[d].vv + cfg[d].vf + cfg[d].vs + cfg[d].vb;
      if (r || m == 0) begin
        ch[d][m] = 0;
        cv[d][m] = 0;
      end else begin
        ch[d][m] = (ch[d][m-1] + 1) % ht;
        cv[d][m] = (ch[d][m] == 0) ? (cv[d][m-1] + 1) % vt : cv[d][m-1];
      end
    end
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    if (m > rel && m <= rel + 1040 && vif0.VGA_HS === 1'b1) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = m;
    end
    if (m >= rel + 351 && m < rel + 351 + 348 && vif1.VGA_VS === 1'b0) vs_cnt++;
    m++;
  endtask

  initial begin
    bit found;
    cfg[0] = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1'b1};
    cfg[1] = '{16, 4, 6, 3, 6, 2, 2, 2, 2, 1'b0};
    m = 0; n_assert = 0; n_fail = 0;
    rel = NCYC; hs_cnt = 0; first_hs = -1; vs_cnt = 0;

    repeat (3) step(1'b1, 3'b101, 1'b0);
    rel = m - 1;

    // Constant pixel across line 0/1 of the full-size raster and several small frames.
    repeat (1200) step(1'b0, 3'b101, 1'b0);
    chk("hs_width_line0", 0, 32'(hs_cnt), 32'd120);
    chk("hs_start_offset", 0, 32'(first_hs - rel), 32'd858);
    chk("vs_width_frame1", 1, 32'(vs_cnt), 32'd58);

    repeat (900) step(1'b0, 3'($urandom), ($urandom % 4) == 0);

    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b0, 3'($urandom), 1'b0);
      if (vif1.PIXEL_H === 11'd10 && vif1.PIXEL_V === 11'd3) found = 1'b1;
    end
    chk("mid_frame_reached", 1, 32'(found), 32'd1);
    step(1'b1, 3'b111, 1'b0);

    repeat (400) step(1'b0, 3'($urandom), ($urandom % 4) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
